// File: rtl/uart_command_responder.sv
// rtl/uart_command_responder.sv - host UART command frame parser and responder
// Decodes 0xAA/0xBB/0xCC/0xDD frames into register-file and ALU strobes and returns result bytes.
module uart_command_responder #(
  parameter int DATA_WIDTH          = 8,
  parameter int REGISTER_FILE_DEPTH = 16,
  parameter int ALU_FUNCTION_WIDTH  = 4,
  localparam int ADDRESS_WIDTH      = $clog2(REGISTER_FILE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_data_valid,
  output logic [ADDRESS_WIDTH-1:0]      rf_address,
  output logic                          rf_write_enable,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  output logic                          rf_read_enable,
  input  logic [DATA_WIDTH-1:0]         rf_read_data,
  input  logic                          rf_read_data_valid,
  output logic                          alu_enable,
  output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
  input  logic [2*DATA_WIDTH-1:0]       alu_result,
  input  logic                          alu_result_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_busy
);

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU   = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, GET_WR_ADDR, GET_WR_DATA, GET_RD_ADDR, RF_READ, GET_OPERAND_A,
    GET_OPERAND_B, GET_FUNCTION, ALU_EXEC, TX_REQUEST, TX_WAIT_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wr_data_q, wr_data_d;
  logic                            we_q, we_d;
  logic                            re_q, re_d;
  logic                            alu_en_q, alu_en_d;
  logic [ALU_FUNCTION_WIDTH-1:0]   func_q, func_d;
  logic [DATA_WIDTH-1:0]           res_hi_q, res_hi_d;
  logic [1:0]                      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]           tx_data_q, tx_data_d;
  logic                            tx_valid_q, tx_valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      alu_en_q   <= 1'b0;
      func_q     <= '0;
      res_hi_q   <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      we_q       <= we_d;
      re_q       <= re_d;
      alu_en_q   <= alu_en_d;
      func_q     <= func_d;
      res_hi_q   <= res_hi_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    alu_en_d   = 1'b0;
    func_d     = func_q;
    res_hi_d   = res_hi_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (rx_data_valid) begin
        if (rx_data == CMD_WRITE)       state_d = GET_WR_ADDR;
        else if (rx_data == CMD_READ)   state_d = GET_RD_ADDR;
        else if (rx_data == CMD_ALU_OP) state_d = GET_OPERAND_A;
        else if (rx_data == CMD_ALU)    state_d = GET_FUNCTION;
      end
      GET_WR_ADDR: if (rx_data_valid) begin
        addr_d  = rx_data[ADDRESS_WIDTH-1:0];
        state_d = GET_WR_DATA;
      end
      GET_WR_DATA: if (rx_data_valid) begin
        wr_data_d = rx_data;
        we_d      = 1'b1;
        state_d   = IDLE;
      end
      GET_RD_ADDR: if (rx_data_valid) begin
        addr_d  = rx_data[ADDRESS_WIDTH-1:0];
        re_d    = 1'b1;
        state_d = RF_READ;
      end
      RF_READ: if (rf_read_data_valid) begin
        tx_data_d = rf_read_data;
        cnt_d     = 2'd1;
        state_d   = TX_REQUEST;
      end
      GET_OPERAND_A: if (rx_data_valid) begin
        addr_d    = '0;
        wr_data_d = rx_data;
        we_d      = 1'b1;
        state_d   = GET_OPERAND_B;
      end
      GET_OPERAND_B: if (rx_data_valid) begin
        addr_d    = ADDRESS_WIDTH'(1);
        wr_data_d = rx_data;
        we_d      = 1'b1;
        state_d   = GET_FUNCTION;
      end
      GET_FUNCTION: if (rx_data_valid) begin
        func_d   = rx_data[ALU_FUNCTION_WIDTH-1:0];
        alu_en_d = 1'b1;
        state_d  = ALU_EXEC;
      end
      ALU_EXEC: if (alu_result_valid) begin
        tx_data_d = alu_result[DATA_WIDTH-1:0];
        res_hi_d  = alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
        cnt_d     = 2'd2;
        state_d   = TX_REQUEST;
      end
      // Request is only raised while the transmitter is idle and dropped once it reports busy.
      TX_REQUEST: begin
        if (tx_valid_q && tx_busy) state_d = TX_WAIT_DONE;
        else                       tx_valid_d = !tx_busy;
      end
      TX_WAIT_DONE: if (!tx_busy) begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = IDLE;
        end else begin
          tx_data_d = res_hi_q;
          state_d   = TX_REQUEST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_address      = addr_q;
  assign rf_write_enable = we_q;
  assign rf_write_data   = wr_data_q;
  assign rf_read_enable  = re_q;
  assign alu_enable      = alu_en_q;
  assign alu_function    = func_q;
  assign tx_data         = tx_data_q;
  assign tx_data_valid   = tx_valid_q;

endmodule

// File: tb/tb_uart_command_responder.sv
// tb/tb_uart_command_responder.sv - directed self-checking bench for uart_command_responder
// Behavioural register file, ALU and transmitter models surround the responder.
module tb_uart_command_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0;
  logic [3:0]  rf_address;
  logic        rf_write_enable;
  logic [7:0]  rf_write_data;
  logic        rf_read_enable;
  logic [7:0]  rf_read_data = 8'h00;
  logic        rf_read_data_valid = 1'b0;
  logic        alu_enable;
  logic [3:0]  alu_function;
  logic [15:0] alu_result = 16'h0000;
  logic        alu_result_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_busy = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rd_value = 8'h00;
  logic [15:0] alu_value = 16'h0000;
  logic        tx_auto = 1'b1;

  logic [7:0] sent_q[$];
  logic [3:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  logic [3:0] re_addr_q[$];
  logic [3:0] alu_func_q[$];
  int tx_valid_cycles = 0;
  int excl_err = 0;
  int hold_err = 0;
  int drop_err = 0;
  int rise_busy_err = 0;
  logic prev_valid = 1'b0;

  uart_command_responder dut (
    .clk                (clk),
    .reset              (reset),
    .rx_data            (rx_data),
    .rx_data_valid      (rx_data_valid),
    .rf_address         (rf_address),
    .rf_write_enable    (rf_write_enable),
    .rf_write_data      (rf_write_data),
    .rf_read_enable     (rf_read_enable),
    .rf_read_data       (rf_read_data),
    .rf_read_data_valid (rf_read_data_valid),
    .alu_enable         (alu_enable),
    .alu_function       (alu_function),
    .alu_result         (alu_result),
    .alu_result_valid   (alu_result_valid),
    .tx_data            (tx_data),
    .tx_data_valid      (tx_data_valid),
    .tx_busy            (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sent(input int n, input string tag);
    int k;
    k = 0;
    while (sent_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(tag, sent_q.size(), n);
    idle_cycles(10);
  endtask

  always @(negedge clk) begin
    if (rf_write_enable) begin
      we_addr_q.push_back(rf_address);
      we_data_q.push_back(rf_write_data);
    end
    if (rf_read_enable) re_addr_q.push_back(rf_address);
    if (alu_enable) alu_func_q.push_back(alu_function);
    if (tx_data_valid) tx_valid_cycles++;
    if (int'(rf_write_enable) + int'(rf_read_enable) + int'(alu_enable) > 1) excl_err++;
    if (tx_data_valid && !prev_valid && tx_busy) rise_busy_err++;
    prev_valid = tx_data_valid;
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rf_read_enable) begin
        repeat (2) @(posedge clk);
        #1;
        rf_read_data = rd_value;
        rf_read_data_valid = 1'b1;
        @(posedge clk); #1;
        rf_read_data_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (alu_enable) begin
        repeat (3) @(posedge clk);
        #1;
        alu_result = alu_value;
        alu_result_valid = 1'b1;
        @(posedge clk); #1;
        alu_result_valid = 1'b0;
      end
    end
  end

  // Transmitter: waits a few cycles after a request, accepts it, stays busy a few cycles.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk); #2;
      if (tx_auto && tx_data_valid && !tx_busy) begin
        b = tx_data;
        repeat (3) begin
          @(posedge clk); #2;
          if (!tx_data_valid || tx_data !== b) hold_err++;
        end
        tx_busy = 1'b1;
        sent_q.push_back(b);
        @(posedge clk); #2;
        if (tx_data_valid) drop_err++;
        repeat (3) @(posedge clk);
        #2;
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    int base_we, base_re, base_alu, base_sent, base_txv, k;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_strobes", {29'd0, rf_write_enable, rf_read_enable, alu_enable}, 32'd0);
    check("reset_tx", {23'd0, tx_data_valid, tx_data}, 32'd0);
    check("reset_addr_func", {24'd0, rf_address, alu_function}, 32'd0);
    check("reset_wdata", {24'd0, rf_write_data}, 32'd0);
    idle_cycles(3);
    reset = 1'b1;
    idle_cycles(2);

    // Write frame
    base_txv = tx_valid_cycles;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle_cycles(10);
    check("wr_count", we_addr_q.size(), 1);
    if (we_addr_q.size() >= 1) begin
      check("wr_addr", we_addr_q[0], 4'h5);
      check("wr_data", we_data_q[0], 8'h3C);
    end
    check("wr_no_tx", tx_valid_cycles - base_txv, 0);

    // Read frame
    rd_value = 8'h3C;
    base_sent = sent_q.size();
    send_byte(8'hBB); send_byte(8'h05);
    wait_sent(base_sent + 1, "rd_sent_timeout");
    check("rd_count", re_addr_q.size(), 1);
    if (re_addr_q.size() >= 1) check("rd_addr", re_addr_q[0], 4'h5);
    if (sent_q.size() > base_sent) check("rd_byte", sent_q[base_sent], 8'h3C);
    idle_cycles(20);
    check("rd_one_byte", sent_q.size(), base_sent + 1);

    // ALU frame with operands
    alu_value = 16'h01C8;
    base_we = we_addr_q.size();
    base_sent = sent_q.size();
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h14); send_byte(8'h02);
    wait_sent(base_sent + 2, "aluop_sent_timeout");
    check("aluop_wr_count", we_addr_q.size() - base_we, 2);
    if (we_addr_q.size() >= base_we + 2) begin
      check("aluop_wr0", {we_addr_q[base_we], we_data_q[base_we]}, 12'h00A);
      check("aluop_wr1", {we_addr_q[base_we+1], we_data_q[base_we+1]}, 12'h114);
    end
    check("aluop_en_count", alu_func_q.size(), 1);
    if (alu_func_q.size() >= 1) check("aluop_func", alu_func_q[0], 4'h2);
    check("aluop_func_hold", alu_function, 4'h2);
    if (sent_q.size() >= base_sent + 2) begin
      check("aluop_lo", sent_q[base_sent], 8'hC8);
      check("aluop_hi", sent_q[base_sent+1], 8'h01);
    end

    // ALU frame without operands; a byte arriving during TX_WAIT_DONE must be dropped
    alu_value = 16'h001E;
    base_we = we_addr_q.size();
    base_alu = alu_func_q.size();
    base_sent = sent_q.size();
    send_byte(8'hDD); send_byte(8'h00);
    k = 0;
    while (!tx_busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("alu_busy_timeout", tx_busy, 1'b1);
    send_byte(8'hAA);
    wait_sent(base_sent + 2, "alu_sent_timeout");
    check("alu_no_writes", we_addr_q.size() - base_we, 0);
    check("alu_en_count", alu_func_q.size() - base_alu, 1);
    check("alu_func", alu_function, 4'h0);
    if (sent_q.size() >= base_sent + 2) begin
      check("alu_lo", sent_q[base_sent], 8'h1E);
      check("alu_hi", sent_q[base_sent+1], 8'h00);
    end
    send_byte(8'h03); send_byte(8'h44);
    idle_cycles(10);
    check("wait_byte_dropped", we_addr_q.size() - base_we, 0);

    // Stray byte, then a write to the top address
    base_we = we_addr_q.size();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h77);
    idle_cycles(10);
    check("robust_wr_count", we_addr_q.size() - base_we, 1);
    if (we_addr_q.size() > base_we) begin
      check("robust_addr", we_addr_q[base_we], 4'hF);
      check("robust_data", we_data_q[base_we], 8'h77);
    end

    // Reset while holding a request in TX_REQUEST
    tx_auto = 1'b0;
    rd_value = 8'h99;
    send_byte(8'hBB); send_byte(8'h07);
    k = 0;
    while (!tx_data_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_req_timeout", tx_data_valid, 1'b1);
    check("rst_req_data", tx_data, 8'h99);
    #2 reset = 1'b0;
    #1;
    check("rst_async_tx", {23'd0, tx_data_valid, tx_data}, 32'd0);
    check("rst_async_misc", {16'd0, rf_write_enable, rf_read_enable, alu_enable, rf_address, alu_function, 3'd0},
          32'd0);
    idle_cycles(2);
    reset = 1'b1;
    tx_auto = 1'b1;
    idle_cycles(2);
    rd_value = 8'h5A;
    base_re = re_addr_q.size();
    base_sent = sent_q.size();
    send_byte(8'hBB); send_byte(8'h02);
    wait_sent(base_sent + 1, "post_rst_timeout");
    check("post_rst_rd_count", re_addr_q.size() - base_re, 1);
    if (re_addr_q.size() > base_re) check("post_rst_addr", re_addr_q[base_re], 4'h2);
    if (sent_q.size() > base_sent) check("post_rst_byte", sent_q[base_sent], 8'h5A);

    check("strobe_exclusive", excl_err, 0);
    check("tx_hold_stable", hold_err, 0);
    check("tx_drop_on_busy", drop_err, 0);
    check("tx_rise_while_busy", rise_busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_command_responder.md
Name: uart_command_responder

Overview:
Responder end of the host UART command protocol. It sits in the reference-clock domain between the UART receiver/transmitter (through the data synchronizers) and the register file and ALU. It parses received command frames 0xAA, 0xBB, 0xCC and 0xDD, performs the register-file or ALU operation, and returns result bytes to the UART transmitter.

Parameters:
DATA_WIDTH, 8, width of a UART byte, of register-file data and of ALU operands.
REGISTER_FILE_DEPTH, 16, number of register-file entries.
ALU_FUNCTION_WIDTH, 4, width of the ALU function select.
ADDRESS_WIDTH (localparam), $clog2(REGISTER_FILE_DEPTH), register-file address width.

Ports:
clk  input  1  reference clock
reset  input  1  asynchronous active-low reset
rx_data  input  DATA_WIDTH  received byte, already synchronized
rx_data_valid  input  1  one-cycle pulse per received byte
rf_address  output  ADDRESS_WIDTH  register-file address
rf_write_enable  output  1  register-file write strobe, 1 cycle
rf_write_data  output  DATA_WIDTH  register-file write data
rf_read_enable  output  1  register-file read strobe, 1 cycle
rf_read_data  input  DATA_WIDTH  register-file read data
rf_read_data_valid  input  1  read data valid, 1 cycle
alu_enable  output  1  ALU start strobe, 1 cycle
alu_function  output  ALU_FUNCTION_WIDTH  ALU operation select
alu_result  input  2*DATA_WIDTH  ALU result
alu_result_valid  input  1  ALU result valid, 1 cycle
tx_data  output  DATA_WIDTH  byte to transmit
tx_data_valid  output  1  transmit request, level
tx_busy  input  1  transmitter busy, already synchronized

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. All outputs are 0. Internal result and byte counters are cleared. Reset mid-frame or mid-response abandons the frame and drops tx_data_valid immediately.
- Bytes are consumed only on rx_data_valid=1.
- Addresses are taken from rx_data[ADDRESS_WIDTH-1:0]; upper bits are ignored.
- Function select is taken from rx_data[ALU_FUNCTION_WIDTH-1:0].
- FSM states: IDLE, GET_WR_ADDR, GET_WR_DATA, GET_RD_ADDR, RF_READ, GET_OPERAND_A, GET_OPERAND_B, GET_FUNCTION, ALU_EXEC, TX_REQUEST, TX_WAIT_DONE.
- IDLE transitions by command byte:
  - 0xAA -> GET_WR_ADDR
  - 0xBB -> GET_RD_ADDR
  - 0xCC -> GET_OPERAND_A
  - 0xDD -> GET_FUNCTION
  - any other byte is discarded; FSM stays in IDLE.
- Write frame (0xAA):
  - GET_WR_ADDR latches the address.
  - GET_WR_DATA, on the data byte, asserts rf_write_enable for exactly 1 cycle with the latched rf_address and rf_write_data = byte, then returns to IDLE. No response byte is sent.
- Read frame (0xBB):
  - GET_RD_ADDR, on the address byte, pulses rf_read_enable for 1 cycle, then enters RF_READ.
  - In RF_READ, rf_read_data_valid latches the byte as the single response byte (byte count 1).
- Operand frame (0xCC):
  - Operand A is written to address 0 (rf_write_enable pulse); operand B is written to address 1.
  - Then GET_FUNCTION.
- Function byte (0xCC and 0xDD frames):
  - GET_FUNCTION, on the function byte, drives alu_function and pulses alu_enable for 1 cycle, then enters ALU_EXEC.
  - alu_function holds its value until the next function byte.
  - In ALU_EXEC, alu_result_valid latches the 2*DATA_WIDTH result; byte count is 2.
- Response:
  - TX_REQUEST drives tx_data and raises tx_data_valid. tx_data is the result low byte first for the ALU, or the read byte.
  - tx_data_valid and tx_data are held stable until tx_busy=1 is sampled, then tx_data_valid is deasserted and the FSM enters TX_WAIT_DONE.
  - In TX_WAIT_DONE, tx_busy=0 decrements the byte count. If bytes remain, the FSM returns to TX_REQUEST with the high byte; otherwise it returns to IDLE.
  - tx_data_valid is never raised while tx_busy=1.
- Bytes received outside the IDLE/GET_* states (RF_READ, ALU_EXEC, TX_*) are dropped.
- rf_write_enable, rf_read_enable and alu_enable are mutually exclusive and are never asserted in the same cycle.
- A valid strobe arriving in the same cycle the FSM enters a waiting state is accepted.
- No timeout: an absent rf_read_data_valid or alu_result_valid stalls the FSM until reset.

Test Plan:
- Write: bytes 0xAA, 0x05, 0x3C -> single rf_write_enable pulse with rf_address=5 and rf_write_data=0x3C; tx_data_valid never asserted.
- Read: bytes 0xBB, 0x05; rf_read_data=0x3C returned -> one rf_read_enable pulse at address 5; tx_data=0x3C is held until tx_busy rises; exactly one byte is sent.
- ALU with operands: bytes 0xCC, 0x0A, 0x14, 0x02; alu_result=0x01C8 -> writes 0x0A@0 and 0x14@1, alu_function=2, one alu_enable pulse; bytes sent are 0xC8 then 0x01, the second only after tx_busy falls.
- ALU without operands: bytes 0xDD, 0x00; alu_result=0x001E -> no register-file writes; sent bytes 0x1E then 0x00.
- Robustness: bytes 0x55 then 0xAA, 0x0F, 0x77 -> 0x55 ignored, write of 0x77 to address 15. A byte received during TX_WAIT_DONE is dropped.
- Reset mid-operation: reset pulled low while in TX_REQUEST -> all outputs are 0 asynchronously. After release, a fresh 0xBB frame completes normally.
